fde_pipe_seq: RTL and testbench

- Sequencer for the 3-stage fetch/decode/execute register bank of the RISC core. Each bit of that bank is a clear-on-disable flop: load enable high captures data; load enable low clears the flop to 0, i.e. inserts a bubble.
- Drives per-stage load enables, recirculation (hold) selects and PC write enable.
- Handles pipeline fill, stall, multicycle execute, flush and halt.
- All outputs are a Moore decode of a registered state, plus a retire counter.

---
 rtl/fde_pipe_seq_if.sv | 38 +++
 rtl/fde_pipe_seq.sv | 168 ++++++++++++++++
 tb/tb_fde_pipe_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fde_pipe_seq_if.sv
// Request/enable bundle between the pipeline control logic and the F/D/E sequencer.
// Latency: none, wires only.
// Backpressure: none; requests are levels sampled by the sequencer each clock.
interface fde_pipe_seq_if #(
    parameter int CYC_W  = 3,
    parameter int RCNT_W = 16
);
    // requests into the sequencer
    logic              run;
    logic              stall_req;
    logic              flush_req;
    logic              halt_req;
    logic              ex_multi;
    logic [CYC_W-1:0]  ex_cycles;

    // register-bank controls and status out of the sequencer
    logic              ld_f;
    logic              ld_d;
    logic              ld_e;
    logic              hold_f;
    logic              hold_d;
    logic              pc_we;
    logic              halted;
    logic [2:0]        state;
    logic [RCNT_W-1:0] retire_cnt;

    // master: the side issuing requests and consuming the enables
    modport master (
        output run, stall_req, flush_req, halt_req, ex_multi, ex_cycles,
        input  ld_f, ld_d, ld_e, hold_f, hold_d, pc_we, halted, state, retire_cnt
    );

    // slave: the sequencer itself
    modport slave (
        input  run, stall_req, flush_req, halt_req, ex_multi, ex_cycles,
        output ld_f, ld_d, ld_e, hold_f, hold_d, pc_we, halted, state, retire_cnt
    );
endinterface

// File: rtl/fde_pipe_seq.sv
// Sequencer for the fetch/decode/execute register bank: fill, stall, multicycle, flush, halt.
// Latency: every output is a Moore decode of registered state, changing one cycle after a request.
// Backpressure: stall/multicycle recirculate F and D (hold + load) and bubble E; no input path to outputs.
module fde_pipe_seq #(
    parameter int CYC_W  = 3,
    parameter int RCNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    fde_pipe_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL1 = 3'd1,
        S_FILL2 = 3'd2,
        S_RUN   = 3'd3,
        S_STALL = 3'd4,
        S_MULTI = 3'd5,
        S_HALT  = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CNT_ZERO = '0;

    state_t            state_q;
    state_t            state_d;
    logic [CYC_W-1:0]  cnt_q;
    logic [CYC_W-1:0]  cnt_d;
    logic [RCNT_W-1:0] retire_q;
    logic              multi_go;

    logic              ld_f_c;
    logic              ld_d_c;
    logic              ld_e_c;
    logic              hold_f_c;
    logic              hold_d_c;
    logic              pc_we_c;
    logic              halted_c;

    // A multicycle instruction of 0 or 1 cycles behaves exactly like a single-cycle one.
    assign multi_go = bus.ex_multi && (bus.ex_cycles > CNT_ONE);

    // State and multicycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Retire counter: one count per cycle spent in RUN, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else if (state_q == S_RUN) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    // Next-state: flush beats halt beats multicycle beats stall while in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FILL1;
            end
            S_FILL1: begin
                state_d = bus.flush_req ? S_FILL1 : S_FILL2;
            end
            S_FILL2: begin
                state_d = bus.flush_req ? S_FILL1 : S_RUN;
            end
            S_RUN: begin
                if (bus.flush_req) begin
                    state_d = S_FILL1;
                end else if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (multi_go) begin
                    state_d = S_MULTI;
                    cnt_d   = bus.ex_cycles - CNT_ONE;
                end else if (bus.stall_req) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (bus.flush_req)      state_d = S_FILL1;
                else if (bus.stall_req) state_d = S_STALL;
                else                    state_d = S_RUN;
            end
            S_MULTI: begin
                // Remaining-cycle count was latched on entry; requests other than flush are ignored.
                if (bus.flush_req) begin
                    state_d = S_FILL1;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_HALT: begin
                if (bus.run) state_d = S_FILL1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode; any hold is paired with its load so recirculated data is not cleared.
    always_comb begin
        ld_f_c   = 1'b0;
        ld_d_c   = 1'b0;
        ld_e_c   = 1'b0;
        hold_f_c = 1'b0;
        hold_d_c = 1'b0;
        pc_we_c  = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            S_FILL1: begin
                ld_f_c  = 1'b1;
                pc_we_c = 1'b1;
            end
            S_FILL2: begin
                ld_f_c  = 1'b1;
                ld_d_c  = 1'b1;
                pc_we_c = 1'b1;
            end
            S_RUN: begin
                ld_f_c  = 1'b1;
                ld_d_c  = 1'b1;
                ld_e_c  = 1'b1;
                pc_we_c = 1'b1;
            end
            S_STALL, S_MULTI: begin
                ld_f_c   = 1'b1;
                ld_d_c   = 1'b1;
                hold_f_c = 1'b1;
                hold_d_c = 1'b1;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                halted_c = 1'b0;
            end
        endcase
    end

    assign bus.ld_f       = ld_f_c;
    assign bus.ld_d       = ld_d_c;
    assign bus.ld_e       = ld_e_c;
    assign bus.hold_f     = hold_f_c;
    assign bus.hold_d     = hold_d_c;
    assign bus.pc_we      = pc_we_c;
    assign bus.halted     = halted_c;
    assign bus.state      = state_q;
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_fde_pipe_seq.sv
// Self-checking bench for fde_pipe_seq: directed scenarios plus random requests against a behavioural model.
// Latency: model advances at each rising edge, outputs compared at each falling edge.
// Backpressure: n/a (bench drives requests freely).
module tb_fde_pipe_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fde_pipe_seq_if #(.CYC_W(3), .RCNT_W(16)) bus ();
    fde_pipe_seq_if #(.CYC_W(3), .RCNT_W(4))  bus4 ();

    fde_pipe_seq #(.CYC_W(3), .RCNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fde_pipe_seq #(.CYC_W(3), .RCNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int chk = 0;
    int err = 0;

    // Model: current phase code, MULTI cycles still to spend, total RUN cycles seen.
    int m_st  = 0;
    int m_rem = 0;
    int m_ret = 0;

    task automatic cmp(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Spec output table {ld_f,ld_d,ld_e,hold_f,hold_d,pc_we}
    function automatic int exp_vec(input int st);
        case (st)
            1:       return 6'b100_00_1;
            2:       return 6'b110_00_1;
            3:       return 6'b111_00_1;
            4, 5:    return 6'b110_11_0;
            default: return 6'b000_00_0;
        endcase
    endfunction

    function automatic int dut_vec();
        return int'({bus.ld_f, bus.ld_d, bus.ld_e, bus.hold_f, bus.hold_d, bus.pc_we});
    endfunction

    function automatic int dut4_vec();
        return int'({bus4.ld_f, bus4.ld_d, bus4.ld_e, bus4.hold_f, bus4.hold_d, bus4.pc_we});
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic h,
                         input logic m, input logic [2:0] c);
        bus.run  = r; bus.stall_req  = s; bus.flush_req  = f;
        bus.halt_req  = h; bus.ex_multi  = m; bus.ex_cycles  = c;
        bus4.run = r; bus4.stall_req = s; bus4.flush_req = f;
        bus4.halt_req = h; bus4.ex_multi = m; bus4.ex_cycles = c;
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_rem = 0;
        m_ret = 0;
    endtask

    // One rising edge of the specified behaviour, driven by the current request levels.
    task automatic model_edge();
        int cyc;
        cyc = int'(bus.ex_cycles);
        if (m_st == 3) m_ret++;
        case (m_st)
            0: if (bus.run) m_st = 1;
            1, 2: m_st = bus.flush_req ? 1 : m_st + 1;
            3: begin
                if (bus.flush_req)                  m_st = 1;
                else if (bus.halt_req)              m_st = 6;
                else if (bus.ex_multi && cyc >= 2) begin
                    m_st  = 5;
                    m_rem = cyc - 1;
                end
                else if (bus.stall_req)             m_st = 4;
            end
            4: m_st = bus.flush_req ? 1 : (bus.stall_req ? 4 : 3);
            5: begin
                if (bus.flush_req) begin
                    m_st  = 1;
                    m_rem = 0;
                end else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_st = 3;
                end
            end
            6: if (bus.run) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic h,
                        input logic m, input logic [2:0] c);
        drive(r, s, f, h, m, c);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 3'd0);
    endtask

    task automatic count_multi(input logic [2:0] c, output int n);
        step(0, 0, 0, 0, 1, c);
        n = 0;
        while (bus.state == 3'd5 && n < 20) begin
            n++;
            idle();
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("state",      int'(bus.state),      m_st);
        cmp("enables",    dut_vec(),            exp_vec(m_st));
        cmp("halted",     int'(bus.halted),     (m_st == 6) ? 1 : 0);
        cmp("retire16",   int'(bus.retire_cnt), m_ret % 65536);
        cmp("state_w4",   int'(bus4.state),     m_st);
        cmp("enables_w4", dut4_vec(),           exp_vec(m_st));
        cmp("retire4",    int'(bus4.retire_cnt), m_ret % 16);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int r0;
        int r4;
        drive(0, 0, 0, 0, 0, 3'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp("rst_state",  int'(bus.state), 0);
        cmp("rst_vec",    dut_vec(), 0);
        cmp("rst_retire", int'(bus.retire_cnt), 0);
        rst = 1'b0;
        idle();
        cmp("post_rst_state", int'(bus.state), 0);
        cmp("post_rst_vec",   dut_vec(), 0);

        // fill sequence
        step(1, 0, 0, 0, 0, 3'd0);
        cmp("fill1_state", int'(bus.state), 1);
        cmp("fill1_vec",   dut_vec(), 6'b100001);
        idle();
        cmp("fill2_state", int'(bus.state), 2);
        cmp("fill2_vec",   dut_vec(), 6'b110001);
        idle();
        cmp("run_state", int'(bus.state), 3);
        cmp("run_vec",   dut_vec(), 6'b111001);
        repeat (5) idle();
        cmp("retire5", int'(bus.retire_cnt), 5);

        // three-cycle stall
        r0 = int'(bus.retire_cnt);
        repeat (3) begin
            step(0, 1, 0, 0, 0, 3'd0);
            cmp("stall_state", int'(bus.state), 4);
            cmp("stall_vec",   dut_vec(), 6'b110110);
        end
        cmp("stall_retire", int'(bus.retire_cnt), r0 + 1);
        idle();
        cmp("stall_exit", int'(bus.state), 3);
        cmp("stall_retire_hold", int'(bus.retire_cnt), r0 + 1);

        // multicycle lengths
        count_multi(3'd4, n);
        cmp("multi4_cycles", n, 3);
        cmp("multi4_exit", int'(bus.state), 3);
        count_multi(3'd1, n);
        cmp("multi1_cycles", n, 0);
        count_multi(3'd7, n);
        cmp("multi7_cycles", n, 6);
        cmp("multi7_exit", int'(bus.state), 3);

        // flush in 2nd MULTI cycle
        step(0, 0, 0, 0, 1, 3'd5);
        idle();
        cmp("multi_2nd", int'(bus.state), 5);
        step(0, 0, 1, 0, 0, 3'd0);
        cmp("flush_multi_state", int'(bus.state), 1);
        cmp("flush_multi_vec",   dut_vec(), 6'b100001);
        idle();
        cmp("flush_multi_f2", int'(bus.state), 2);
        idle();
        cmp("flush_multi_run", int'(bus.state), 3);

        // flush in STALL
        step(0, 1, 0, 0, 0, 3'd0);
        step(0, 1, 1, 0, 0, 3'd0);
        cmp("flush_stall_state", int'(bus.state), 1);
        cmp("flush_stall_vec",   dut_vec(), 6'b100001);
        idle();
        idle();
        cmp("flush_stall_run", int'(bus.state), 3);

        // flush in FILL2
        step(0, 0, 1, 0, 0, 3'd0);
        idle();
        cmp("fill2_reached", int'(bus.state), 2);
        step(0, 0, 1, 0, 0, 3'd0);
        cmp("flush_fill2_state", int'(bus.state), 1);
        idle();
        idle();
        cmp("flush_fill2_run", int'(bus.state), 3);

        // everything at once: flush wins
        step(0, 1, 1, 1, 1, 3'd6);
        cmp("all_req_state", int'(bus.state), 1);
        idle();
        idle();

        // halt, flush ignored in HALT, restart
        step(0, 0, 0, 1, 0, 3'd0);
        cmp("halt_state",  int'(bus.state), 6);
        cmp("halt_halted", int'(bus.halted), 1);
        cmp("halt_vec",    dut_vec(), 0);
        step(0, 0, 1, 0, 0, 3'd0);
        cmp("halt_flush_ignored", int'(bus.state), 6);
        step(1, 0, 0, 0, 0, 3'd0);
        cmp("halt_restart", int'(bus.state), 1);
        idle();
        idle();

        // 16 RUN cycles wrap the 4-bit counter back to where it was
        r0 = int'(bus.retire_cnt);
        r4 = int'(bus4.retire_cnt);
        repeat (16) idle();
        cmp("wrap4", int'(bus4.retire_cnt), r4);
        cmp("retire16_adv", int'(bus.retire_cnt), (r0 + 16) % 65536);

        // randomized traffic
        repeat (3000) begin
            step(($urandom_range(99) < 30), ($urandom_range(99) < 25),
                 ($urandom_range(99) < 5),  ($urandom_range(99) < 5),
                 ($urandom_range(99) < 20), 3'($urandom_range(7)));
        end

        // async reset in the middle of a MULTI
        step(1, 0, 0, 0, 0, 3'd0);
        while (bus.state != 3'd3 && n < 40) begin
            n++;
            step(1, 0, 0, 0, 0, 3'd0);
        end
        step(0, 0, 0, 0, 1, 3'd7);
        idle();
        cmp("pre_arst_state", int'(bus.state), 5);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        cmp("arst_state",    int'(bus.state), 0);
        cmp("arst_vec",      dut_vec(), 0);
        cmp("arst_retire",   int'(bus.retire_cnt), 0);
        cmp("arst_retire4",  int'(bus4.retire_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        cmp("arst_release_state", int'(bus.state), 0);
        cmp("arst_release_vec",   dut_vec(), 0);
        step(1, 0, 0, 0, 0, 3'd0);
        cmp("arst_restart", int'(bus.state), 1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
